// File: rtl/exc_sequencer_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// exc_sequencer_pkg: shared codes, vectors and state encoding
// Rev 1.0
// ------------------------------------------------------------------
package exc_sequencer_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] BEV_BASE    = 32'hBFC0_0200;
  localparam logic [11:0] OFF_REFILL  = 12'h000;
  localparam logic [11:0] OFF_GENERAL = 12'h180;
  localparam logic [11:0] OFF_INT     = 12'h200;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COMMIT   = 2'd1,
    ST_ERET     = 2'd2,
    ST_REDIRECT = 2'd3
  } state_e;

  typedef struct packed {
    logic [4:0]  code;
    logic [31:0] pc;
    logic        bd;
    logic        refill;
    logic [31:0] badv;
    logic        badv_we;
    logic        exl;
  } exc_latch_t;

  function automatic logic [31:0] exc_vector(input logic bev, input logic [19:0] ebase,
                                             input logic iv, input logic [4:0] code,
                                             input logic refill, input logic exl);
    logic [31:0] base;
    logic [11:0] off;
    base = bev ? BEV_BASE : {ebase, 12'h000};
    if (refill && !exl)
      off = OFF_REFILL;
    else if (code == EXC_INT && iv)
      off = OFF_INT;
    else
      off = OFF_GENERAL;
    return base + {20'd0, off};
  endfunction

endpackage
`default_nettype wire

// File: rtl/exc_sequencer_if.sv
`default_nettype none
// ------------------------------------------------------------------
// exc_sequencer_if: fetch redirect valid/ready channel
// Rev 1.0
// ------------------------------------------------------------------
interface exc_sequencer_if;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        redirect_ready_i;

  modport master (output redirect_valid_o, output redirect_pc_o, input redirect_ready_i);
  modport slave  (input redirect_valid_o, input redirect_pc_o, output redirect_ready_i);
endinterface
`default_nettype wire

// File: rtl/exc_sequencer_int_sync.sv
`default_nettype none
// ------------------------------------------------------------------
// exc_sequencer_int_sync: SYNC_STAGES-deep flop chain for async lines
// Rev 1.0
// ------------------------------------------------------------------
module exc_sequencer_int_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = 5
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic [WIDTH-1:0] async_in,
  output logic      [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        stage[i] <= '0;
    end else begin
      stage[0] <= async_in;
      for (int i = 1; i < SYNC_STAGES; i++)
        stage[i] <= stage[i-1];
    end
  end

  assign sync_out = stage[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/exc_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// exc_sequencer: arbitrates exceptions/interrupts/ERET, drives CP0 and fetch redirect
// Rev 1.0
// ------------------------------------------------------------------
module exc_sequencer
  import exc_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HW_INT_W    = 5
) (
  input  wire logic                clk,
  input  wire logic                rst_n,
  input  wire logic [HW_INT_W-1:0] hw_int_async,
  input  wire logic                timer_int,
  output logic      [HW_INT_W:0]   hardware_int_o,
  input  wire logic                exp_req_i,
  input  wire logic [4:0]          exp_code_i,
  input  wire logic [31:0]         exp_pc_i,
  input  wire logic                exp_bd_i,
  input  wire logic                exp_refill_i,
  input  wire logic [31:0]         exp_badv_i,
  input  wire logic                exp_badv_we_i,
  input  wire logic                eret_i,
  input  wire logic [31:0]         int_pc_i,
  input  wire logic                int_bd_i,
  input  wire logic                int_pc_valid_i,
  input  wire logic                allow_int,
  input  wire logic                in_exl,
  input  wire logic                boot_exp_vec,
  input  wire logic                special_int_vec,
  input  wire logic [7:0]          interrupt_mask,
  input  wire logic [1:0]          software_int,
  input  wire logic [19:0]         ebase,
  input  wire logic [31:0]         cp0_epc,
  output logic                     en_exp_o,
  output logic      [4:0]          exp_code_o,
  output logic      [31:0]         exp_epc_o,
  output logic                     exp_bd_o,
  output logic      [31:0]         exp_bad_vaddr_o,
  output logic                     exp_badv_we_o,
  output logic                     clean_exl_o,
  output logic                     flush_o,
  exc_sequencer_if.master          redir
);

  state_e          state;
  state_e          next_state;
  exc_latch_t      lat;
  logic [31:0]     target;
  logic [HW_INT_W-1:0] hw_sync;
  logic            int_pend;

  exc_sequencer_int_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .WIDTH       (HW_INT_W)
  ) u_hw_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (hw_int_async),
    .sync_out (hw_sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      hardware_int_o <= '0;
    else
      hardware_int_o <= {timer_int, hw_sync};
  end

  assign int_pend = allow_int & int_pc_valid_i &
                    (|({hardware_int_o, software_int} & interrupt_mask));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (exp_req_i)
          next_state = ST_COMMIT;
        else if (eret_i)
          next_state = ST_ERET;
        else if (int_pend)
          next_state = ST_COMMIT;
      end
      ST_COMMIT,
      ST_ERET:     next_state = ST_REDIRECT;
      ST_REDIRECT: if (redir.redirect_ready_i) next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  // in_exl is captured at accept; the vector inputs are read in COMMIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat    <= '0;
      target <= '0;
    end else begin
      if (state == ST_IDLE) begin
        if (exp_req_i)
          lat <= '{code: exp_code_i, pc: exp_pc_i, bd: exp_bd_i, refill: exp_refill_i,
                   badv: exp_badv_i, badv_we: exp_badv_we_i, exl: in_exl};
        else if (!eret_i && int_pend)
          lat <= '{code: EXC_INT, pc: int_pc_i, bd: int_bd_i, refill: 1'b0,
                   badv: 32'd0, badv_we: 1'b0, exl: in_exl};
      end
      if (state == ST_COMMIT)
        target <= exc_vector(boot_exp_vec, ebase, special_int_vec, lat.code, lat.refill, lat.exl);
      else if (state == ST_ERET)
        target <= cp0_epc;
    end
  end

  always_comb begin
    en_exp_o              = 1'b0;
    exp_code_o            = '0;
    exp_epc_o             = '0;
    exp_bd_o              = 1'b0;
    exp_bad_vaddr_o       = '0;
    exp_badv_we_o         = 1'b0;
    clean_exl_o           = 1'b0;
    flush_o               = 1'b0;
    redir.redirect_valid_o = 1'b0;
    redir.redirect_pc_o    = '0;
    case (state)
      ST_COMMIT: begin
        en_exp_o        = 1'b1;
        flush_o         = 1'b1;
        exp_code_o      = lat.code;
        exp_epc_o       = lat.bd ? (lat.pc - 32'd4) : lat.pc;
        exp_bd_o        = lat.bd;
        exp_bad_vaddr_o = lat.badv;
        exp_badv_we_o   = lat.badv_we;
      end
      ST_ERET: begin
        clean_exl_o = 1'b1;
        flush_o     = 1'b1;
      end
      ST_REDIRECT: begin
        flush_o                = 1'b1;
        redir.redirect_valid_o = 1'b1;
        redir.redirect_pc_o    = target;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_exc_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_exc_sequencer: scoreboard bench with a spec-level reference model
// Rev 1.0
// ------------------------------------------------------------------
module tb_exc_sequencer;

  localparam int HW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [HW-1:0] hw_int_async = '0;
  logic timer_int = 1'b0;
  logic [HW:0] hardware_int_o;
  logic exp_req_i = 0, exp_bd_i = 0, exp_refill_i = 0, exp_badv_we_i = 0, eret_i = 0;
  logic [4:0]  exp_code_i = '0;
  logic [31:0] exp_pc_i = '0, exp_badv_i = '0, int_pc_i = '0, cp0_epc = '0;
  logic int_bd_i = 0, int_pc_valid_i = 0, allow_int = 0, in_exl = 0;
  logic boot_exp_vec = 0, special_int_vec = 0;
  logic [7:0]  interrupt_mask = '0;
  logic [1:0]  software_int = '0;
  logic [19:0] ebase = '0;
  logic en_exp_o, exp_bd_o, exp_badv_we_o, clean_exl_o, flush_o;
  logic [4:0]  exp_code_o;
  logic [31:0] exp_epc_o, exp_bad_vaddr_o;

  exc_sequencer_if rif ();

  exc_sequencer #(.SYNC_STAGES(2), .HW_INT_W(HW)) dut (
    .clk(clk), .rst_n(rst_n), .hw_int_async(hw_int_async), .timer_int(timer_int),
    .hardware_int_o(hardware_int_o), .exp_req_i(exp_req_i), .exp_code_i(exp_code_i),
    .exp_pc_i(exp_pc_i), .exp_bd_i(exp_bd_i), .exp_refill_i(exp_refill_i),
    .exp_badv_i(exp_badv_i), .exp_badv_we_i(exp_badv_we_i), .eret_i(eret_i),
    .int_pc_i(int_pc_i), .int_bd_i(int_bd_i), .int_pc_valid_i(int_pc_valid_i),
    .allow_int(allow_int), .in_exl(in_exl), .boot_exp_vec(boot_exp_vec),
    .special_int_vec(special_int_vec), .interrupt_mask(interrupt_mask),
    .software_int(software_int), .ebase(ebase), .cp0_epc(cp0_epc),
    .en_exp_o(en_exp_o), .exp_code_o(exp_code_o), .exp_epc_o(exp_epc_o),
    .exp_bd_o(exp_bd_o), .exp_bad_vaddr_o(exp_bad_vaddr_o), .exp_badv_we_o(exp_badv_we_o),
    .clean_exl_o(clean_exl_o), .flush_o(flush_o), .redir(rif)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_eret;
    bit          is_int;
    logic [4:0]  code;
    logic [31:0] epc;
    logic        bd;
    logic [31:0] badv;
    logic        bwe;
  } ev_t;

  ev_t         evq[$];
  logic [31:0] tq[$];
  int n_checks = 0, n_fail = 0;
  int hs_count = 0, n_commits = 0, hold_cycles = 0;
  logic        prev_wait = 1'b0;
  logic [31:0] prev_pc = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference vector rule written straight from the architecture definition
  function automatic logic [31:0] model_vec(input bit bev, input logic [19:0] eb, input bit iv,
                                            input logic [4:0] code, input bit refill, input bit exl);
    logic [31:0] base;
    base = bev ? 32'hBFC00200 : (32'(eb) << 12);
    if (refill && !exl) return base;
    if (code == 5'd0 && iv) return base + 32'h200;
    return base + 32'h180;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (hold_cycles > 0) begin
        rif.redirect_ready_i = 1'b0;
        hold_cycles--;
      end else begin
        rif.redirect_ready_i = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_wait = 1'b0;
      end else begin
        if (en_exp_o || clean_exl_o) begin
          chk("strobe_flush", flush_o, 1);
          if (en_exp_o) n_commits++;
          if (evq.size() == 0) begin
            chk("unexpected_strobe", {en_exp_o, clean_exl_o}, 0);
          end else begin
            e = evq.pop_front();
            chk("strobe_kind", {en_exp_o, clean_exl_o}, e.is_eret ? 2'b01 : 2'b10);
            if (en_exp_o) begin
              chk("exp_code", exp_code_o, e.code);
              chk("exp_epc", exp_epc_o, e.epc);
              chk("exp_bd", exp_bd_o, e.bd);
              chk("exp_badv_we", exp_badv_we_o, e.bwe);
              if (!e.is_int) chk("exp_badv", exp_bad_vaddr_o, e.badv);
            end
          end
        end
        if (rif.redirect_valid_o) begin
          chk("redirect_flush", flush_o, 1);
          if (prev_wait) chk("redirect_hold", rif.redirect_pc_o, prev_pc);
          if (rif.redirect_ready_i) begin
            hs_count++;
            if (tq.size() == 0) chk("unexpected_redirect", rif.redirect_valid_o, 0);
            else chk("redirect_pc", rif.redirect_pc_o, tq.pop_front());
          end
          prev_wait = !rif.redirect_ready_i;
          prev_pc   = rif.redirect_pc_o;
        end else begin
          if (prev_wait) chk("redirect_dropped", rif.redirect_valid_o, 1);
          prev_wait = 1'b0;
        end
      end
    end
  end

  task automatic wait_done(input bit noise);
    int start;
    int n;
    start = hs_count;
    n = 0;
    while (hs_count == start && n < 300) begin
      if (noise) begin
        exp_req_i  = 1'($urandom_range(0, 1));
        eret_i     = 1'($urandom_range(0, 1));
        exp_code_i = 5'($urandom);
        exp_pc_i   = $urandom;
      end
      tick();
      n++;
    end
    exp_req_i = 1'b0;
    eret_i    = 1'b0;
    if (n >= 300) chk("handshake_timeout", hs_count, start + 1);
    else chk("idle_after_handshake", rif.redirect_valid_o, 0);
  endtask

  task automatic send_exc(input logic [4:0] code, input logic [31:0] pc, input bit bd,
                          input bit refill, input logic [31:0] badv, input bit bwe,
                          input bit exl, input bit with_eret, input bit with_int,
                          input bit noise, input bit do_wait);
    ev_t e;
    exp_req_i = 1; exp_code_i = code; exp_pc_i = pc; exp_bd_i = bd;
    exp_refill_i = refill; exp_badv_i = badv; exp_badv_we_i = bwe; in_exl = exl;
    eret_i = with_eret;
    if (with_int) begin allow_int = 1; int_pc_valid_i = 1; int_pc_i = pc ^ 32'h100; end
    e = '{is_eret: 0, is_int: 0, code: code, epc: bd ? pc - 32'd4 : pc, bd: bd, badv: badv, bwe: bwe};
    evq.push_back(e);
    tq.push_back(model_vec(boot_exp_vec, ebase, special_int_vec, code, refill, exl));
    tick();
    exp_req_i = 0; eret_i = 0; allow_int = 0; int_pc_valid_i = 0; in_exl = ~exl;
    if (do_wait) wait_done(noise);
  endtask

  task automatic send_eret(input logic [31:0] epc, input bit noise);
    ev_t e;
    eret_i  = 1;
    cp0_epc = ~epc;
    e = '{is_eret: 1, is_int: 0, code: 0, epc: 0, bd: 0, badv: 0, bwe: 0};
    evq.push_back(e);
    tq.push_back(epc);
    tick();
    eret_i  = 0;
    cp0_epc = epc;
    wait_done(noise);
  endtask

  task automatic send_int(input logic [HW-1:0] hw, input bit tmr, input logic [1:0] sw,
                          input logic [7:0] mask, input logic [31:0] pc, input bit bd,
                          input bit exl, input bit noise);
    ev_t e;
    bit  pend;
    hw_int_async = hw; timer_int = tmr; software_int = sw;
    repeat (4) tick();
    chk("hwint_settled", hardware_int_o, {tmr, hw});
    pend = |({tmr, hw, sw} & mask);
    interrupt_mask = mask; allow_int = 1; int_pc_valid_i = 1;
    int_pc_i = pc; int_bd_i = bd; in_exl = exl;
    if (pend) begin
      e = '{is_eret: 0, is_int: 1, code: 0, epc: bd ? pc - 32'd4 : pc, bd: bd, badv: 0, bwe: 0};
      evq.push_back(e);
      tq.push_back(model_vec(boot_exp_vec, ebase, special_int_vec, 5'd0, 1'b0, exl));
    end
    tick();
    allow_int = 0; int_pc_valid_i = 0; in_exl = ~exl;
    if (pend) wait_done(noise);
    else repeat (4) tick();
  endtask

  initial begin
    logic [4:0] codes [10];
    int c0;
    int nval;
    codes = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};

    #12;
    chk("rst_en_exp", en_exp_o, 0);
    chk("rst_redirect_valid", rif.redirect_valid_o, 0);
    chk("rst_hwint", hardware_int_o, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("idle_flush", flush_o, 0);

    // BEV vector, plain exception
    boot_exp_vec = 1;
    send_exc(5'd10, 32'h80000040, 0, 0, 32'h1234, 0, 0, 0, 0, 0, 1);

    // refill vector depends on EXL, delay-slot EPC
    boot_exp_vec = 0; ebase = 20'h80000; special_int_vec = 0;
    send_exc(5'd2, 32'h80001004, 1, 1, 32'hDEAD0000, 1, 0, 0, 0, 0, 1);
    send_exc(5'd2, 32'h80001004, 1, 1, 32'hDEAD0004, 1, 1, 0, 0, 0, 1);

    // synchroniser latency then interrupt via IV
    hw_int_async = 5'b00001;
    repeat (2) tick();
    chk("hwint_not_yet", hardware_int_o[0], 0);
    tick();
    chk("hwint_latency", hardware_int_o[0], 1);
    special_int_vec = 1;
    send_int(5'b00001, 0, 2'b00, 8'h04, 32'h80002000, 0, 0, 0);
    c0 = n_commits;
    send_int(5'b00001, 0, 2'b00, 8'h00, 32'h80002000, 0, 0, 0);
    chk("masked_no_commit", n_commits, c0);

    // exception beats eret and interrupt; then eret alone
    interrupt_mask = 8'h04;
    send_exc(5'd12, 32'h80003000, 0, 0, 32'h0, 0, 0, 1, 1, 0, 1);
    send_eret(32'h80000123, 0);

    // redirect stalled with request noise
    hold_cycles = 7;
    send_exc(5'd8, 32'h80004000, 0, 0, 32'h0, 0, 0, 0, 0, 1, 1);

    // reset in REDIRECT
    hold_cycles = 1000;
    send_exc(5'd9, 32'h80005000, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    nval = 0;
    while (!rif.redirect_valid_o && nval < 10) begin tick(); nval++; end
    chk("reach_redirect", rif.redirect_valid_o, 1);
    #3;
    rst_n = 1'b0;
    evq.delete();
    tq.delete();
    #1;
    chk("async_rst_valid", rif.redirect_valid_o, 0);
    chk("async_rst_pc", rif.redirect_pc_o, 0);
    chk("async_rst_flush", flush_o, 0);
    chk("async_rst_hwint", hardware_int_o, 0);
    hold_cycles = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("no_stale_redirect", rif.redirect_valid_o, 0);

    // randomized traffic
    for (int it = 0; it < 150; it++) begin
      int kind;
      boot_exp_vec    = 1'($urandom_range(0, 1));
      ebase           = 20'($urandom);
      special_int_vec = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) hold_cycles = $urandom_range(1, 6);
      kind = $urandom_range(0, 2);
      if (kind == 0)
        send_exc(codes[$urandom_range(0, 9)], $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
                 1'($urandom_range(0, 1)), 1);
      else if (kind == 1)
        send_eret($urandom, 1'($urandom_range(0, 1)));
      else
        send_int(HW'($urandom), 1'($urandom_range(0, 1)), 2'($urandom), 8'($urandom),
                 $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) tick();
    end

    repeat (5) tick();
    chk("events_drained", evq.size(), 0);
    chk("targets_drained", tq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, failures so far=%0d", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
